// File: rtl/grf_multiport.sv
// rtl/grf_multiport.sv - multi-read, dual-write register file with busy scoreboard
//
// Purpose: 2^AW x DW general-purpose register file with NRP combinational
// read ports, two prioritised write ports (port 1 beats port 0 on an address
// collision), an optional hardwired zero register and a per-register busy
// scoreboard with a registered population count.
//
// Optional feature macro: GRF_BYPASS_EN (write-to-read forwarding on rd).
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset; clears RF, busy bits, busy_cnt
//   ra        NRP read addresses, port k at [k*AW +: AW]
//   rd        NRP read data, port k at [k*DW +: DW]
//   rbusy     busy bit of the register addressed by each read port
//   we0/wa0/wd0  write port 0 (writeback)
//   we1/wa1/wd1  write port 1 (late commit, higher priority)
//   sb_set    mark register sb_addr busy
//   sb_addr   register to mark busy
//   busy_cnt  number of busy registers

module grf_multiport #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRP      = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP*DW-1:0] rd,
    output logic [NRP-1:0]    rbusy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    output logic [AW:0]       busy_cnt
);

    localparam int DEPTH = 1 << AW;

    logic                         zero_en;
    logic [DEPTH-1:0][DW-1:0]     rf;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_nxt;
    logic [AW:0]                  cnt_nxt;
    logic                         w0_ok;
    logic                         w1_ok;

    assign zero_en = (ZERO_REG != 0);

    // Port 0 is suppressed when port 1 hits the same address so only wd1 lands.
    assign w1_ok = we1 && !(zero_en && wa1 == '0);
    assign w0_ok = we0 && !(zero_en && wa0 == '0) && !(we1 && wa1 == wa0);

    // Clears first, then the set, so a same-address set wins.
    always_comb begin
        busy_nxt = busy;
        if (we0) busy_nxt[wa0] = 1'b0;
        if (we1) busy_nxt[wa1] = 1'b0;
        if (sb_set && !(zero_en && sb_addr == '0)) busy_nxt[sb_addr] = 1'b1;
        if (zero_en) busy_nxt[0] = 1'b0;
    end

    // Count is taken from the next state so busy_cnt tracks busy exactly.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf       <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (w0_ok) rf[wa0] <= wd0;
            if (w1_ok) rf[wa1] <= wd1;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // rbusy always reflects registered state; only data may be forwarded.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int k = 0; k < NRP; k++) begin
            rd[k*DW +: DW] = rf[ra[k*AW +: AW]];
`ifdef GRF_BYPASS_EN
            if (we1 && wa1 == ra[k*AW +: AW]) begin
                rd[k*DW +: DW] = wd1;
            end else if (we0 && wa0 == ra[k*AW +: AW]) begin
                rd[k*DW +: DW] = wd0;
            end
`endif
            if (zero_en && ra[k*AW +: AW] == '0) rd[k*DW +: DW] = '0;
            rbusy[k] = busy[ra[k*AW +: AW]];
        end
    end

endmodule

// File: tb/tb_grf_multiport.sv
// tb/tb_grf_multiport.sv - randomized self-checking bench for grf_multiport

module tb_grf_multiport;

    logic        clk;
    logic        reset;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [2:0]  rbusy;
    logic        we0, we1, sb_set;
    logic [4:0]  wa0, wa1, sb_addr;
    logic [31:0] wd0, wd1;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_rf   [32];
    bit          m_busy [32];

    grf_multiport #(.DW(32), .AW(5), .NRP(3), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef GRF_BYPASS_EN
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
`endif
        return m_rf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_edge();
        if (we0 && wa0 != 0 && !(we1 && wa1 == wa0)) m_rf[wa0] = wd0;
        if (we1 && wa1 != 0) m_rf[wa1] = wd1;
        if (we0) m_busy[wa0] = 1'b0;
        if (we1) m_busy[wa1] = 1'b0;
        if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_rd"}, rd[k*32 +: 32], exp_rd(ra[k*5 +: 5]));
            chk({tag, "_rbusy"}, rbusy[k], m_busy[ra[k*5 +: 5]]);
        end
        chk({tag, "_cnt"}, busy_cnt, model_cnt());
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; sb_set = 0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic tick(input string tag);
        #2;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
    endtask

    initial begin
        logic [4:0] a0, a1, a2;
        int prev_cnt;

        reset = 1'b0;
        idle_inputs();
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; sb_addr = 0;
        set_ra(5'd1, 5'd2, 5'd31);
        model_clear();
        #3;
        chk("reset_rd", rd, 96'h0);
        chk("reset_rbusy", rbusy, 3'b0);
        chk("reset_cnt", busy_cnt, 6'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Scoreboard sequence
        sb_set = 1; sb_addr = 7; set_ra(5'd7, 5'd0, 5'd0);
        tick("sb1");
        chk("sb_set_busy", rbusy[0], 1'b1);
        chk("sb_set_cnt", busy_cnt, 6'd1);
        sb_set = 1; sb_addr = 7; we0 = 1; wa0 = 7; wd0 = 32'h77;
        tick("sb2");
        chk("sb_setclr_busy", rbusy[0], 1'b1);
        chk("sb_setclr_data", rd[31:0], 32'h77);
        chk("sb_setclr_cnt", busy_cnt, 6'd1);
        we0 = 1; wa0 = 7; wd0 = 32'h78;
        tick("sb3");
        chk("sb_clr_busy", rbusy[0], 1'b0);
        chk("sb_clr_cnt", busy_cnt, 6'd0);

        // Zero register with one other register busy
        sb_set = 1; sb_addr = 9;
        tick("zr0");
        prev_cnt = model_cnt();
        we0 = 1; wa0 = 0; wd0 = 32'hDEAD_BEEF; sb_set = 1; sb_addr = 0;
        set_ra(5'd0, 5'd9, 5'd0);
        tick("zr1");
        chk("zero_rd", rd[31:0], 32'h0);
        chk("zero_rbusy", rbusy[0], 1'b0);
        chk("zero_cnt", busy_cnt, 6'(prev_cnt));
        chk("zero_other_busy", rbusy[1], 1'b1);

        // Dual write collision
        we0 = 1; we1 = 1; wa0 = 5; wa1 = 5; wd0 = 32'h1111_1111; wd1 = 32'h2222_2222;
        set_ra(5'd5, 5'd5, 5'd5);
        tick("col");
        chk("collision_rd", rd[31:0], 32'h2222_2222);

        // Same-cycle read of a register being written
        we0 = 1; wa0 = 3; wd0 = 32'hA;
        tick("byp0");
        set_ra(5'd3, 5'd4, 5'd0);
        we0 = 1; wa0 = 3; wd0 = 32'hB;
        #2;
`ifdef GRF_BYPASS_EN
        chk("bypass_same", rd[31:0], 32'hB);
`else
        chk("bypass_same", rd[31:0], 32'hA);
`endif
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
        chk("bypass_next", rd[31:0], 32'hB);

        // Fill every register with 4*i through port 0
        for (int i = 0; i < 32; i++) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'(i * 4);
            tick("fill");
        end
        set_ra(5'd0, 5'd17, 5'd31);
        #2;
        chk("all_p0", rd[31:0], 32'h0);
        chk("all_p1", rd[63:32], 32'd68);
        chk("all_p2", rd[95:64], 32'd124);
        for (int t = 0; t < 6; t++) begin
            a0 = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            set_ra(a0, a1, a2);
            #1;
            chk("all_r0", rd[31:0], 32'(a0) * 4);
            chk("all_r1", rd[63:32], 32'(a1) * 4);
            chk("all_r2", rd[95:64], 32'(a2) * 4);
        end
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = ($urandom_range(0, 2) == 0);
            wa0 = 5'($urandom);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            sb_set = 1'($urandom_range(0, 1));
            sb_addr = ($urandom_range(0, 4) == 0) ? wa0 : 5'($urandom);
            a0 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom);
            a2 = 5'($urandom);
            set_ra(a0, a1, a2);
            tick("rnd");
        end
        check_outputs("rnd_end");

        // Asynchronous reset between edges, with a write in flight
        set_ra(5'd1, 5'd2, 5'd3);
        we0 = 1; wa0 = 2; wd0 = 32'h5555_5555; sb_set = 1; sb_addr = 3;
        #2 reset = 1'b0;
        #1;
        chk("areset_rd", rd, 96'h0);
        chk("areset_rbusy", rbusy, 3'b0);
        chk("areset_cnt", busy_cnt, 6'd0);
        model_clear();
        #4;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        tick("post_reset");
        chk("post_reset_rd", rd, 96'h0);
        chk("post_reset_cnt", busy_cnt, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grf_multiport.md
# grf_multiport

Parametrised general-purpose register file for the pipelined CPU; successor to the single-write, two-read GRF. Provides NRP combinational read ports, two prioritised write ports (WB and late-commit), a hardwired zero register, and a per-register busy scoreboard for the hazard unit. Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- `DW`, 32: data width in bits.
- `AW`, 5: address width; depth is 2^AW registers.
- `NRP`, 3: number of read ports, at least 1.
- `ZERO_REG`, 1: 1 = register 0 reads 0 and ignores writes and busy-set; 0 = register 0 is ordinary.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; clears all registers and busy bits.
- `ra` in NRP*AW: read addresses; port k uses bits [k*AW +: AW].
- `rd` out NRP*DW: read data, packed the same way.
- `rbusy` out NRP: busy bit of the register addressed by port k.
- `we0` in 1: write port 0 enable (WB stage).
- `wa0` in AW: write port 0 address.
- `wd0` in DW: write port 0 data.
- `we1` in 1: write port 1 enable (late commit); higher priority than port 0.
- `wa1` in AW: write port 1 address.
- `wd1` in DW: write port 1 data.
- `sb_set` in 1: mark a register busy (decode issues a producer).
- `sb_addr` in AW: register to mark busy.
- `busy_cnt` out AW+1: number of registers currently busy.

## Operation
- Storage: 2^AW x DW flops, updated on rising `clk` when `reset` is high.
- Write: `we0`/`we1` write `wd0`/`wd1` at the edge. If both target the same address, only `wd1` is stored.
- Zero register: with `ZERO_REG`=1, writes to address 0 are dropped, reads of address 0 return 0, and `sb_set` to address 0 is ignored.
- Read: `rd[k]` = RF[`ra[k]`] combinationally. Bypass behaviour is set under Configuration.
- Scoreboard: one busy bit per register.
  - Any enabled write to address a clears busy[a] at the edge.
  - `sb_set` sets busy[`sb_addr`] at the edge.
  - When a set and a clear hit the same address in the same cycle, the set wins and the bit ends at 1.
- `rbusy[k]` = busy[`ra[k]`], registered state only. It is never bypassed.
- `busy_cnt` is a registered population count of the busy bits. It is updated in the same edge as the bits, so it always equals the popcount of the current state. Range 0..2^AW (or 2^AW-1 with `ZERO_REG`=1).

## Timing
- Reset (`reset`=0, asynchronous): all RF entries 0, all busy bits 0, `busy_cnt`=0. Consequently every `rd` reads 0 and every `rbusy` reads 0.
- Reset asserted mid-operation: state clears immediately without waiting for `clk`. Writes and sets in flight are discarded.
- Release of reset: the first state change occurs at the first rising edge with `reset`=1.
- Write latency: the value is visible on non-bypassed reads in the cycle after the write edge. With bypass, it is visible in the same cycle.
- Read latency: 0 cycles (combinational from `ra`).
- Scoreboard latency: `rbusy` reflects `sb_set` or a clearing write from the cycle after the edge.

## Configuration
- `GRF_BYPASS_EN` defined: internal write-to-read forwarding.
  - If `we1` is high and `wa1`==`ra[k]`, then `rd[k]`=`wd1`.
  - Otherwise, if `we0` is high and `wa0`==`ra[k]`, then `rd[k]`=`wd0`.
  - Otherwise `rd[k]`=RF[`ra[k]`].
  - Address 0 is still forced to 0 when `ZERO_REG`=1.
- `GRF_BYPASS_EN` undefined: `rd[k]` is always RF[`ra[k]`] (old value during a same-cycle write). External forwarding is the pipeline's job.

## Test plan
- Reset: drive `reset`=0 between edges after writing several registers → all `rd`=0, `rbusy`=0, `busy_cnt`=0 immediately, before the next `clk`.
- Dual write collision: `we0`=`we1`=1, `wa0`=`wa1`=5, `wd0`=0x1111_1111, `wd1`=0x2222_2222 → RF[5] reads 0x2222_2222 next cycle.
- Zero register: write 0xDEAD_BEEF to address 0 and `sb_set` address 0 → `rd`=0, `rbusy`=0, `busy_cnt` unchanged.
- Scoreboard: `sb_set` 7 → `rbusy`=1 and `busy_cnt`=1. Then in one cycle, `sb_set` 7 plus `we0` to 7 → stays busy with new data stored. A further `we0` to 7 → `rbusy`=0 and `busy_cnt`=0.
- Bypass with the macro defined: RF[3]=0xA, same cycle `we0` to 3 with 0xB and `ra[0]`=3 → `rd[0]`=0xB. Without the macro → `rd[0]`=0xA that cycle and 0xB the next.
- All ports: `NRP`=3, all three read ports addressing different registers after 32 sequential writes of i*4 to register i → each `rd` equals 4*address (0 for address 0).
